// File: rtl/vram_sched.sv
// vram_sched: arbitrates screen fetch, CPU, ULA+ palette writes and an optional DMA port
// onto the external video/main SRAM, running each grant as a fixed ADDR/STRB/END cycle.
// Optional DMA port: define VRAM_SCHED_DMA_EN to enable it (disabled by default).
module vram_sched #(
  parameter int unsigned AGE_MAX = 7
) (
  input  logic        clk28,
  input  logic        usrrst_n,
  input  logic        scr_req,
  input  logic [18:0] scr_addr,
  output logic        scr_ack,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [18:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  input  logic        up_req,
  input  logic [18:0] up_addr,
  input  logic [7:0]  up_wdata,
  output logic        up_ack,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [18:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [7:0]  rdata,
  output logic [18:0] va,
  input  logic [7:0]  vd_in,
  output logic [7:0]  vd_out,
  output logic        vd_oe,
  output logic        n_vrd,
  output logic        n_vwr,
  output logic [1:0]  grant,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StAddr, StStrb, StEnd} state_e;

  localparam logic [1:0] OwnScr = 2'd0;
  localparam logic [1:0] OwnCpu = 2'd1;
  localparam logic [1:0] OwnUp  = 2'd2;
  localparam logic [1:0] OwnDma = 2'd3;
  localparam logic [2:0] AgeMax = 3'(AGE_MAX);

  state_e      state;
  logic        we_q;
  logic [2:0]  age_up;
  logic        arb_ok;
  logic        el_scr, el_cpu, el_up, el_dma;
  logic        win_vld;
  logic [1:0]  win;
  logic [18:0] sel_addr;
  logic        sel_we;
  logic [7:0]  sel_wdata;

`ifdef VRAM_SCHED_DMA_EN
  logic [2:0] age_dma;
`else
  logic unused_dma;
  assign unused_dma = ^{dma_req, dma_we, dma_addr, dma_wdata, OwnDma};
  assign dma_ack    = 1'b0;
`endif

  // Eligibility and fixed priority with age promotion; the just-acked owner sits out in END
  always_comb begin
    arb_ok  = (state == StIdle) || (state == StEnd);
    el_scr  = scr_req && !((state == StEnd) && (grant == OwnScr));
    el_cpu  = cpu_req && !((state == StEnd) && (grant == OwnCpu));
    el_up   = up_req  && !((state == StEnd) && (grant == OwnUp));
`ifdef VRAM_SCHED_DMA_EN
    el_dma  = dma_req && !((state == StEnd) && (grant == OwnDma));
`else
    el_dma  = 1'b0;
`endif
    win_vld = 1'b1;
    win     = OwnScr;
    if (el_scr)                            win = OwnScr;
    else if (el_up && (age_up == AgeMax))  win = OwnUp;
`ifdef VRAM_SCHED_DMA_EN
    else if (el_dma && (age_dma == AgeMax)) win = OwnDma;
`endif
    else if (el_cpu)                       win = OwnCpu;
    else if (el_up)                        win = OwnUp;
`ifdef VRAM_SCHED_DMA_EN
    else if (el_dma)                       win = OwnDma;
`endif
    else                                   win_vld = 1'b0;
  end

  // Route the winner's address and write data
  always_comb begin
    sel_addr  = cpu_addr;
    sel_we    = cpu_we;
    sel_wdata = cpu_wdata;
    case (win)
      OwnScr: begin
        sel_addr = scr_addr;
        sel_we   = 1'b0;
      end
      OwnUp: begin
        sel_addr  = up_addr;
        sel_we    = 1'b1;
        sel_wdata = up_wdata;
      end
`ifdef VRAM_SCHED_DMA_EN
      OwnDma: begin
        sel_addr  = dma_addr;
        sel_we    = dma_we;
        sel_wdata = dma_wdata;
      end
`endif
      default: ;
    endcase
  end

  // Age counters: count lost grants while pending, clear on own grant or withdrawn request
  always_ff @(posedge clk28 or negedge usrrst_n) begin
    if (!usrrst_n) begin
      age_up <= 3'd0;
    end else if (!up_req) begin
      age_up <= 3'd0;
    end else if (arb_ok && win_vld) begin
      if (win == OwnUp)                  age_up <= 3'd0;
      else if (el_up && age_up != AgeMax) age_up <= age_up + 3'd1;
    end
  end

`ifdef VRAM_SCHED_DMA_EN
  // DMA age counter, same rules as the ULA+ one
  always_ff @(posedge clk28 or negedge usrrst_n) begin
    if (!usrrst_n) begin
      age_dma <= 3'd0;
    end else if (!dma_req) begin
      age_dma <= 3'd0;
    end else if (arb_ok && win_vld) begin
      if (win == OwnDma)                    age_dma <= 3'd0;
      else if (el_dma && age_dma != AgeMax) age_dma <= age_dma + 3'd1;
    end
  end
`endif

  // SRAM cycle sequencer with registered pins, strobes and acks
  always_ff @(posedge clk28 or negedge usrrst_n) begin
    if (!usrrst_n) begin
      state   <= StIdle;
      we_q    <= 1'b0;
      va      <= '0;
      vd_out  <= '0;
      vd_oe   <= 1'b0;
      n_vrd   <= 1'b1;
      n_vwr   <= 1'b1;
      rdata   <= '0;
      grant   <= OwnScr;
      busy    <= 1'b0;
      scr_ack <= 1'b0;
      cpu_ack <= 1'b0;
      up_ack  <= 1'b0;
`ifdef VRAM_SCHED_DMA_EN
      dma_ack <= 1'b0;
`endif
    end else begin
      scr_ack <= 1'b0;
      cpu_ack <= 1'b0;
      up_ack  <= 1'b0;
`ifdef VRAM_SCHED_DMA_EN
      dma_ack <= 1'b0;
`endif
      unique case (state)
        StIdle, StEnd: begin
          if (win_vld) begin
            state <= StAddr;
            grant <= win;
            busy  <= 1'b1;
            va    <= sel_addr;
            we_q  <= sel_we;
            vd_oe <= sel_we;
            if (sel_we) vd_out <= sel_wdata;
          end else begin
            state <= StIdle;
            busy  <= 1'b0;
            vd_oe <= 1'b0;
          end
        end
        StAddr: begin
          state <= StStrb;
          n_vrd <= we_q;
          n_vwr <= !we_q;
        end
        StStrb: begin
          state   <= StEnd;
          n_vrd   <= 1'b1;
          n_vwr   <= 1'b1;
          if (!we_q) rdata <= vd_in;
          scr_ack <= (grant == OwnScr);
          cpu_ack <= (grant == OwnCpu);
          up_ack  <= (grant == OwnUp);
`ifdef VRAM_SCHED_DMA_EN
          dma_ack <= (grant == OwnDma);
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_sched.sv
// Randomised and directed bench for vram_sched against a transaction-phase reference model.
`timescale 1ns/1ps
module tb_vram_sched;

  localparam int AgeMax = 7;
`ifdef VRAM_SCHED_DMA_EN
  localparam bit DmaEn = 1'b1;
`else
  localparam bit DmaEn = 1'b0;
`endif

  logic        clk28    = 1'b0;
  logic        usrrst_n = 1'b0;
  logic [3:0]  req      = '0;   // 0 scr, 1 cpu, 2 up, 3 dma
  logic [18:0] addr [4];
  logic        we   [4];
  logic [7:0]  wd   [4];
  logic [3:0]  rereq    = '0;
  bit          rand_en  = 1'b0;

  logic        scr_ack, cpu_ack, up_ack, dma_ack, vd_oe, n_vrd, n_vwr, busy;
  logic [7:0]  rdata, vd_out;
  logic [7:0]  vd_in;
  logic [18:0] va;
  logic [1:0]  grant;

  logic [7:0]  sram    [0:524287];
  logic [7:0]  ref_mem [0:524287];

  int errs = 0;
  int checks = 0;

  vram_sched #(.AGE_MAX(AgeMax)) dut (
    .clk28(clk28), .usrrst_n(usrrst_n),
    .scr_req(req[0]), .scr_addr(addr[0]), .scr_ack(scr_ack),
    .cpu_req(req[1]), .cpu_we(we[1]), .cpu_addr(addr[1]), .cpu_wdata(wd[1]), .cpu_ack(cpu_ack),
    .up_req(req[2]), .up_addr(addr[2]), .up_wdata(wd[2]), .up_ack(up_ack),
    .dma_req(req[3]), .dma_we(we[3]), .dma_addr(addr[3]), .dma_wdata(wd[3]), .dma_ack(dma_ack),
    .rdata(rdata), .va(va), .vd_in(vd_in), .vd_out(vd_out), .vd_oe(vd_oe),
    .n_vrd(n_vrd), .n_vwr(n_vwr), .grant(grant), .busy(busy)
  );

  always #5 clk28 = ~clk28;

  // SRAM pad model
  assign vd_in = sram[va];
  always @(posedge clk28) if (!n_vwr && vd_oe) sram[va] <= vd_out;

  wire [3:0]  dut_ack = {dma_ack, up_ack, cpu_ack, scr_ack};
  wire [44:0] dut_vec = {busy, grant, dut_ack, n_vrd, n_vwr, vd_oe, va, vd_out, rdata};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: phase of the current access (0 none, 1..3 cycles into it)
  int          m_phase = 0;
  int          m_owner = 0;
  int          m_age [4] = '{0, 0, 0, 0};
  logic [18:0] m_addr  = '0;
  logic        m_we    = 1'b0;
  logic [7:0]  m_wd    = '0;
  logic [7:0]  m_vdout = '0;
  logic [7:0]  m_rdata = '0;

  task automatic model_step();
    int win;
    bit el [4];
    win = -1;
    for (int r = 0; r < 4; r++)
      el[r] = req[r] && !(m_phase == 3 && m_owner == r) && (r != 3 || DmaEn);
    if (m_phase == 2) begin
      if (m_we) ref_mem[m_addr] = m_wd;
      else      m_rdata = ref_mem[m_addr];
    end
    if (m_phase == 0 || m_phase == 3) begin
      if (el[0])                          win = 0;
      else if (el[2] && m_age[2] == AgeMax) win = 2;
      else if (el[3] && m_age[3] == AgeMax) win = 3;
      else if (el[1])                     win = 1;
      else if (el[2])                     win = 2;
      else if (el[3])                     win = 3;
    end
    for (int r = 2; r < 4; r++) begin
      if (!req[r] || win == r)                          m_age[r] = 0;
      else if (win >= 0 && el[r] && m_age[r] < AgeMax) m_age[r] = m_age[r] + 1;
    end
    if (m_phase == 1 || m_phase == 2) begin
      m_phase = m_phase + 1;
    end else if (win >= 0) begin
      m_owner = win;
      m_addr  = addr[win];
      m_we    = (win == 2) || (win != 0 && we[win]);
      m_wd    = wd[win];
      if (m_we) m_vdout = m_wd;
      m_phase = 1;
    end else begin
      m_phase = 0;
    end
  endtask

  function automatic logic [44:0] exp_vec();
    logic [3:0] ack;
    logic       st;
    ack = (m_phase == 3) ? 4'(1 << m_owner) : 4'b0;
    st  = (m_phase == 2);
    return {m_phase != 0, 2'(m_owner), ack, !(st && !m_we), !(st && m_we),
            (m_phase != 0) && m_we, m_addr, m_vdout, m_rdata};
  endfunction

  initial begin
    forever begin
      @(posedge clk28 or negedge usrrst_n);
      if (!usrrst_n) begin
        m_phase = 0; m_owner = 0; m_addr = '0; m_we = 1'b0;
        m_wd = '0; m_vdout = '0; m_rdata = '0; m_age = '{0, 0, 0, 0};
      end else begin
        model_step();
      end
    end
  end

  // Per-cycle comparison, then requester agents (drop on ack, re-request, random traffic)
  always @(negedge clk28) begin
    if (usrrst_n) begin
      chk("cycle", 64'(dut_vec), 64'(exp_vec()));
      for (int r = 0; r < 4; r++) begin
        if (req[r] && m_phase == 3 && m_owner == r) begin
          req[r] = 1'b0;
        end else if (req[r] && rand_en && !(m_phase != 0 && m_owner == r) &&
                     $urandom_range(0, 39) == 0) begin
          req[r] = 1'b0;
        end else if (!req[r] && (rereq[r] || (rand_en && $urandom_range(0, 3) == 0))) begin
          addr[r] = ($urandom_range(0, 1) == 1) ? 19'($urandom) : 19'($urandom_range(0, 15));
          we[r]   = (r == 2) ? 1'b1 : (r == 0) ? 1'b0 : 1'($urandom_range(0, 1));
          wd[r]   = 8'($urandom);
          req[r]  = 1'b1;
        end
      end
    end
  end

  int          first_ack [4];
  int          vrd_lo, vwr_lo, busy_cnt;
  logic [15:0] oe_pat, vwr_pat;

  task automatic watch(input int n);
    for (int r = 0; r < 4; r++) first_ack[r] = 0;
    vrd_lo = 0; vwr_lo = 0; busy_cnt = 0; oe_pat = '0; vwr_pat = '0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk28);
      for (int r = 0; r < 4; r++) if (dut_ack[r] && first_ack[r] == 0) first_ack[r] = c;
      if (!n_vrd) vrd_lo++;
      if (!n_vwr) vwr_lo++;
      if (busy) busy_cnt++;
      oe_pat  = {oe_pat[14:0], vd_oe};
      vwr_pat = {vwr_pat[14:0], n_vwr};
    end
  endtask

  task automatic raise(input int r, input logic [18:0] a, input logic w, input logic [7:0] d);
    addr[r] = a; we[r] = w; wd[r] = d; req[r] = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin addr[i] = '0; we[i] = 1'b0; wd[i] = '0; end
    for (int i = 0; i < 524288; i++) begin sram[i] = 8'($urandom); ref_mem[i] = sram[i]; end
    repeat (3) @(negedge clk28);
    chk("reset_state", 64'(dut_vec), 64'({1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 1'b0, 19'd0, 8'd0, 8'd0}));
    usrrst_n = 1'b1;
    @(negedge clk28);

    // CPU read
    sram[19'h12345] = 8'hA5; ref_mem[19'h12345] = 8'hA5;
    raise(1, 19'h12345, 1'b0, 8'h00);
    watch(6);
    chk("cpu_rd_latency", 64'(first_ack[1]), 64'd3);
    chk("cpu_rd_strobe_cycles", 64'(vrd_lo), 64'd1);
    chk("cpu_rd_va", 64'(va), 64'h12345);
    chk("cpu_rd_data", 64'(rdata), 64'hA5);

    // Contention scr vs cpu
    raise(0, 19'h00100, 1'b0, 8'h00);
    raise(1, 19'h00200, 1'b1, 8'h5A);
    watch(8);
    chk("cont_scr_ack", 64'(first_ack[0]), 64'd3);
    chk("cont_cpu_ack", 64'(first_ack[1]), 64'd6);

    // ULA+ write timing, then read it back through the CPU
    raise(2, 19'h00040, 1'b1, 8'h3F);
    watch(4);
    chk("up_wr_ack", 64'(first_ack[2]), 64'd3);
    chk("up_wr_oe_pattern", 64'(oe_pat[3:0]), 64'b1110);
    chk("up_wr_nvwr_pattern", 64'(vwr_pat[3:0]), 64'b1011);
    chk("up_wr_vd_out", 64'(vd_out), 64'h3F);
    raise(1, 19'h00040, 1'b0, 8'h00);
    watch(4);
    chk("readback_data", 64'(rdata), 64'h3F);

    // Starvation: scr and cpu re-request continuously, up must get in via aging
    rereq = 4'b0011;
    raise(0, 19'h00300, 1'b0, 8'h00);
    raise(1, 19'h00301, 1'b0, 8'h00);
    raise(2, 19'h00302, 1'b1, 8'hC3);
    watch(30);
    chk("starve_up_ack", 64'(first_ack[2]), 64'd24);
    rereq = 4'b0000;
    repeat (12) @(negedge clk28);

    // Reset in the middle of a CPU write strobe
    raise(1, 19'h00500, 1'b1, 8'h77);
    repeat (2) @(negedge clk28);
    chk("rst_pre_strobe", 64'(n_vwr), 64'd0);
    #2 usrrst_n = 1'b0;
    #1 chk("rst_async_pins", 64'({n_vwr, n_vrd, vd_oe, busy, cpu_ack}), 64'b11000);
    req = '0;
    @(negedge clk28);
    chk("rst_no_ack", 64'(dut_ack), 64'd0);
    usrrst_n = 1'b1;
    @(negedge clk28);

    // DMA port
`ifdef VRAM_SCHED_DMA_EN
    raise(3, 19'h00600, 1'b0, 8'h00);
    watch(6);
    chk("dma_ack_latency", 64'(first_ack[3]), 64'd3);
`else
    raise(3, 19'h00600, 1'b0, 8'h00);
    watch(100);
    chk("nodma_ack", 64'(first_ack[3]), 64'd0);
    chk("nodma_busy", 64'(busy_cnt), 64'd0);
    req[3] = 1'b0;
`endif

    // Random traffic
    rand_en = 1'b1;
    repeat (3000) @(negedge clk28);
    rand_en = 1'b0;
    req[3] = 1'b0;
    repeat (40) @(negedge clk28);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
